// File: rtl/i2c_pkg.sv
// Shared types and default timing for the I2C controller.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } scl_state_t;

  // 400 kHz fast-mode periods at 156.25 MHz
  localparam int DEF_LO_400K = 250;
  localparam int DEF_HI_400K = 140;

endpackage

// File: rtl/i2c_scl_gen_if.sv
// Control and pin bundle between the bit engine and the SCL generator.
interface i2c_scl_gen_if #(
  parameter int CNT_W = 9
);
  logic             en;
  logic [CNT_W-1:0] lo_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic             scl_i;
  logic             scl_t;
  logic             fall_stb;
  logic             upd_stb;
  logic             rise_stb;
  logic             smp_stb;
  logic             stretch;
  logic             busy;

  modport master (
    output en, lo_cnt, hi_cnt, scl_i,
    input  scl_t, fall_stb, upd_stb, rise_stb, smp_stb, stretch, busy
  );

  modport slave (
    input  en, lo_cnt, hi_cnt, scl_i,
    output scl_t, fall_stb, upd_stb, rise_stb, smp_stb, stretch, busy
  );
endinterface

// File: rtl/i2c_sync.sv
// Multi-flop synchroniser for an open-drain pin readback; idles high.
// q_nxt is the value q will take on the next edge, so callers that
// register their decisions can line them up with q without extra delay.
module i2c_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_nxt
);
  logic [STAGES-1:0] ff_q, ff_d;

  // shift the pin value through the chain
  always_comb ff_d = {ff_q[STAGES-2:0], d};

  // chain register, released bus reads as high
  always_ff @(posedge clk) begin
    if (rst) ff_q <= '1;
    else     ff_q <= ff_d;
  end

  assign q     = ff_q[STAGES-1];
  assign q_nxt = ff_q[STAGES-2];
endmodule

// File: rtl/i2c_scl_gen.sv
// SCL generator: programmable low/high periods, clock stretching,
// and single-cycle phase strobes for the bit engine.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int CNT_W       = 9,
  parameter int DEF_LO      = DEF_LO_400K,
  parameter int DEF_HI      = DEF_HI_400K,
  parameter int SYNC_STAGES = 2
) (
  input  logic           CLK,
  input  logic           RST,
  i2c_scl_gen_if.slave   bus
);
  localparam logic [CNT_W-1:0] SYNC_C = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] LO_MIN = CNT_W'(2);
  localparam logic [CNT_W-1:0] HI_MIN = CNT_W'(SYNC_STAGES + 1);

  logic scl_s, scl_s_nxt;

  i2c_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (CLK),
    .rst   (RST),
    .d     (bus.scl_i),
    .q     (scl_s),
    .q_nxt (scl_s_nxt)
  );

  scl_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lo_l_q, lo_l_d;
  logic [CNT_W-1:0] hi_l_q, hi_l_d;
  logic             scl_t_q, scl_t_d;
  logic             fall_stb_q, fall_stb_d;
  logic             upd_stb_q, upd_stb_d;
  logic             rise_stb_q, rise_stb_d;
  logic             smp_stb_q, smp_stb_d;
  logic             stretch_q, stretch_d;
  logic             busy_q, busy_d;
  logic             hold, load;
  logic [CNT_W-1:0] hi_mid;

  // state, counter, latched periods and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lo_l_q     <= CNT_W'(DEF_LO);
      hi_l_q     <= CNT_W'(DEF_HI);
      scl_t_q    <= 1'b1;
      fall_stb_q <= 1'b0;
      upd_stb_q  <= 1'b0;
      rise_stb_q <= 1'b0;
      smp_stb_q  <= 1'b0;
      stretch_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lo_l_q     <= lo_l_d;
      hi_l_q     <= hi_l_d;
      scl_t_q    <= scl_t_d;
      fall_stb_q <= fall_stb_d;
      upd_stb_q  <= upd_stb_d;
      rise_stb_q <= rise_stb_d;
      smp_stb_q  <= smp_stb_d;
      stretch_q  <= stretch_d;
      busy_q     <= busy_d;
    end
  end

  // next state: periods only end on count boundaries, so en never truncates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_l_d  = lo_l_q;
    hi_l_d  = hi_l_q;
    load    = 1'b0;
    // a slave holding SCL low after we released it freezes the high count
    hold    = (state_q == HIGH) && (cnt_q >= SYNC_C) && !scl_s;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en) begin
          state_d = LOW;
          load    = 1'b1;
        end
      end
      LOW: begin
        if (cnt_q == lo_l_q - 1'b1) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (hold) begin
          cnt_d = cnt_q;
        end else if (cnt_q == hi_l_q - 1'b1) begin
          cnt_d = '0;
          if (bus.en) begin
            state_d = LOW;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // clamp so LOW has a midpoint and HIGH outlasts the sync latency
    if (load) begin
      lo_l_d = (bus.lo_cnt < LO_MIN) ? LO_MIN : bus.lo_cnt;
      hi_l_d = (bus.hi_cnt < HI_MIN) ? HI_MIN : bus.hi_cnt;
    end
  end

  // outputs decoded from next-cycle state so they land aligned with it
  always_comb begin
    hi_mid = hi_l_d >> 1;
    // a midpoint inside the sync window is pushed to the confirmed rise
    if (hi_mid < SYNC_C) hi_mid = SYNC_C;
    scl_t_d    = (state_d != LOW);
    busy_d     = (state_d != IDLE);
    fall_stb_d = (state_d == LOW) && (cnt_d == '0);
    upd_stb_d  = (state_d == LOW) && (cnt_d == (lo_l_d >> 1));
    stretch_d  = (state_d == HIGH) && (cnt_d >= SYNC_C) && !scl_s_nxt;
    rise_stb_d = (state_d == HIGH) && (cnt_d == SYNC_C) && scl_s_nxt;
    smp_stb_d  = (state_d == HIGH) && (cnt_d == hi_mid) && !stretch_d;
  end

  assign bus.scl_t    = scl_t_q;
  assign bus.fall_stb = fall_stb_q;
  assign bus.upd_stb  = upd_stb_q;
  assign bus.rise_stb = rise_stb_q;
  assign bus.smp_stb  = smp_stb_q;
  assign bus.stretch  = stretch_q;
  assign bus.busy     = busy_q;
endmodule
